// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - shared VRAM arbiter between a video fetch engine and a Z80-style CPU
//
// Purpose: grants one VRAM access per clock to either the video fetcher or the
// CPU. Video normally has priority. A starvation counter forces a CPU grant
// after STARVE consecutive video grants while the CPU is waiting.
//
// Ports:
//   clk, rstn                     clock and asynchronous active-low reset
//   vid_req, vid_addr             video fetch request (level) and address
//   vid_gnt, vid_ack, vid_data    video grant, read-data valid pulse, read data
//   cpu_req, cpu_we, cpu_addr,    CPU request (held until cpu_done), direction,
//   cpu_wdata                     address and write data
//   cpu_wait, cpu_done, cpu_rdata Z80 wait strobe, completion pulse, latched read data
//   mem_addr, mem_we, mem_wdata   registered VRAM address / write enable / write data
//   mem_rdata                     VRAM read data for the current access cycle
module vram_arbiter #(
  parameter int AW     = 13,
  parameter int DW     = 8,
  parameter int STARVE = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_gnt,
  output logic          vid_ack,
  output logic [DW-1:0] vid_data,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_wait,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE);

  // State names the owner of VRAM during the current cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    VID  = 2'd1,
    CPU  = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [SW-1:0] starve_cnt;
  logic          cpu_elig;

  // A request that just completed (cpu_done high) is not re-granted in the
  // same cycle; a still-held cpu_req becomes a new request the cycle after.
  assign cpu_elig = cpu_req & (state != CPU) & ~cpu_done;

  always_comb begin
    state_nxt = IDLE;
    if (cpu_elig && (starve_cnt == STARVE_MAX)) begin
      state_nxt = CPU;
    end else if (vid_req) begin
      state_nxt = VID;
    end else if (cpu_elig) begin
      state_nxt = CPU;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Counts video grants that overtake a waiting CPU; saturates at STARVE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (!cpu_req || (state_nxt == CPU)) begin
      starve_cnt <= '0;
    end else if ((state_nxt == VID) && cpu_elig && (starve_cnt != STARVE_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Memory command registers are loaded on the edge entering each state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      case (state_nxt)
        VID: begin
          mem_addr <= vid_addr;
          mem_we   <= 1'b0;
        end
        CPU: begin
          mem_addr  <= cpu_addr;
          mem_we    <= cpu_we;
          mem_wdata <= cpu_wdata;
        end
        default: begin
          mem_we <= 1'b0;
        end
      endcase
    end
  end

  // Completion of the access that owned VRAM during the cycle now ending.
  // mem_we still reflects the direction of that access, so it gates the
  // read-data latch and cpu_rdata is untouched by writes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vid_ack   <= 1'b0;
      vid_data  <= '0;
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
    end else begin
      vid_ack  <= (state == VID);
      cpu_done <= (state == CPU);
      if (state == VID) begin
        vid_data <= mem_rdata;
      end
      if ((state == CPU) && !mem_we) begin
        cpu_rdata <= mem_rdata;
      end
    end
  end

  assign vid_gnt  = (state == VID);
  assign cpu_wait = cpu_req & ~cpu_done;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed self-checking bench for vram_arbiter
module tb_vram_arbiter;

  logic        clk;
  logic        rstn;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic        vid_gnt;
  logic        vid_ack;
  logic [7:0]  vid_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_wait;
  logic        cpu_done;
  logic [7:0]  cpu_rdata;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.AW(13), .DW(8), .STARVE(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .vid_req   (vid_req),
    .vid_addr  (vid_addr),
    .vid_gnt   (vid_gnt),
    .vid_ack   (vid_ack),
    .vid_data  (vid_data),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_wait  (cpu_wait),
    .cpu_done  (cpu_done),
    .cpu_rdata (cpu_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // VRAM model: asynchronous read of the registered address, write at the
  // edge ending a write cycle. Preload pattern is known to the bench.
  function automatic logic [7:0] init_pat(input logic [12:0] a);
    return (a == 13'h0123) ? 8'hA5 : (a[7:0] ^ 8'h5A);
  endfunction

  logic [7:0] vram [0:8191];

  initial begin
    for (int i = 0; i < 8192; i++) vram[i] = init_pat(13'(i));
    forever begin
      @(posedge clk);
      if (mem_we) vram[mem_addr] <= mem_wdata;
    end
  end

  assign mem_rdata = vram[mem_addr];

  task automatic test_reset;
    rstn = 1'b0; vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0;
    vid_addr = 13'h0; cpu_addr = 13'h0; cpu_wdata = 8'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (vid_gnt !== 1'b0 || vid_ack !== 1'b0 || cpu_done !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got gnt=%b ack=%b done=%b want 0 0 0", vid_gnt, vid_ack, cpu_done);
    end
    checks++;
    if (mem_addr !== 13'h0 || mem_we !== 1'b0 || mem_wdata !== 8'h0) begin
      errors++; $display("FAIL reset_mem got addr=%h we=%b wdata=%h want 0 0 0", mem_addr, mem_we, mem_wdata);
    end
    checks++;
    if (vid_data !== 8'h0 || cpu_rdata !== 8'h0) begin
      errors++; $display("FAIL reset_data got vid_data=%h cpu_rdata=%h want 00 00", vid_data, cpu_rdata);
    end
    checks++;
    if (cpu_wait !== 1'b1) begin
      errors++; $display("FAIL reset_wait got %b want 1", cpu_wait);
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (vid_gnt !== 1'b0 || cpu_wait !== 1'b0 || cpu_done !== 1'b0) begin
      errors++; $display("FAIL post_reset_idle got gnt=%b wait=%b done=%b want 0 0 0", vid_gnt, cpu_wait, cpu_done);
    end
  endtask

  task automatic test_cpu_read;
    cpu_we = 1'b0; cpu_addr = 13'h0123; cpu_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_addr !== 13'h0123 || mem_we !== 1'b0 || vid_gnt !== 1'b0 || cpu_done !== 1'b0 || cpu_wait !== 1'b1) begin
      errors++; $display("FAIL cpu_read_grant got addr=%h we=%b gnt=%b done=%b wait=%b want 0123 0 0 0 1",
                         mem_addr, mem_we, vid_gnt, cpu_done, cpu_wait);
    end
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 8'hA5 || cpu_wait !== 1'b0) begin
      errors++; $display("FAIL cpu_read_done got done=%b rdata=%h wait=%b want 1 a5 0", cpu_done, cpu_rdata, cpu_wait);
    end
    cpu_req = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b0) begin
      errors++; $display("FAIL cpu_read_pulse got done=%b want 0", cpu_done);
    end
  endtask

  task automatic test_cpu_write;
    cpu_we = 1'b1; cpu_addr = 13'h0010; cpu_wdata = 8'h3C; cpu_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 13'h0010 || mem_wdata !== 8'h3C) begin
      errors++; $display("FAIL cpu_write_cycle got we=%b addr=%h wdata=%h want 1 0010 3c", mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 8'hA5 || mem_we !== 1'b0) begin
      errors++; $display("FAIL cpu_write_done got done=%b rdata=%h we=%b want 1 a5 0", cpu_done, cpu_rdata, mem_we);
    end
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_video_stream;
    vid_addr = 13'h0100; vid_req = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (i < 8) begin
        if (vid_gnt !== 1'b1 || mem_addr !== 13'(13'h0100 + i)) begin
          errors++; $display("FAIL vid_grant[%0d] got gnt=%b addr=%h want 1 %h", i, vid_gnt, mem_addr, 13'(13'h0100 + i));
        end
      end else begin
        if (vid_gnt !== 1'b0) begin
          errors++; $display("FAIL vid_grant_end got gnt=%b want 0", vid_gnt);
        end
      end
      if (i > 0) begin
        checks++;
        if (vid_ack !== 1'b1 || vid_data !== init_pat(13'(13'h0100 + i - 1))) begin
          errors++; $display("FAIL vid_ack[%0d] got ack=%b data=%h want 1 %h", i - 1, vid_ack, vid_data,
                             init_pat(13'(13'h0100 + i - 1)));
        end
      end
      if (vid_gnt) vid_addr = vid_addr + 13'h1;
      if (i == 7) vid_req = 1'b0;
    end
  endtask

  task automatic test_idle;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (vid_ack !== 1'b0 || cpu_done !== 1'b0 || vid_gnt !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 13'h0107) begin
        errors++; $display("FAIL idle got ack=%b done=%b gnt=%b we=%b addr=%h want 0 0 0 0 0107",
                           vid_ack, cpu_done, vid_gnt, mem_we, mem_addr);
      end
    end
  endtask

  // Counts video grants between cpu_req rising and cpu_done; also checks
  // that video owns the memory again in the done cycle and done is single.
  task automatic run_contention(input string name, input logic [7:0] exp_rdata);
    int  n_vid;
    int  n_done;
    bit  seen;
    logic resumed;
    logic [7:0] rd;
    n_vid = 0; n_done = 0; seen = 1'b0; resumed = 1'b0; rd = 8'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (cpu_done) begin
        n_done++;
        if (!seen) begin
          resumed = vid_gnt;
          rd = cpu_rdata;
        end
        seen = 1'b1;
        cpu_req = 1'b0;
      end else if (!seen && vid_gnt) begin
        n_vid++;
      end
    end
    checks++;
    if (n_vid != 4) begin
      errors++; $display("FAIL %s_vid_grants got %0d want 4", name, n_vid);
    end
    checks++;
    if (n_done != 1) begin
      errors++; $display("FAIL %s_done_count got %0d want 1", name, n_done);
    end
    checks++;
    if (resumed !== 1'b1 || rd !== exp_rdata) begin
      errors++; $display("FAIL %s_resume got gnt=%b rdata=%h want 1 %h", name, resumed, rd, exp_rdata);
    end
    vid_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_simultaneous;
    vid_addr = 13'h0200; cpu_we = 1'b0; cpu_addr = 13'h0010;
    vid_req = 1'b1; cpu_req = 1'b1;
    @(negedge clk);
    checks++;
    if (vid_gnt !== 1'b1 || mem_addr !== 13'h0200) begin
      errors++; $display("FAIL simultaneous_first got gnt=%b addr=%h want 1 0200", vid_gnt, mem_addr);
    end
    // The first video grant above is one of the four tolerated ones.
    begin
      int n_vid;
      int n_done;
      n_vid = 1; n_done = 0;
      for (int i = 0; i < 10 && n_done == 0; i++) begin
        @(negedge clk);
        if (cpu_done) begin
          n_done++;
          checks++;
          if (cpu_rdata !== 8'h3C) begin
            errors++; $display("FAIL simultaneous_rdata got %h want 3c", cpu_rdata);
          end
          cpu_req = 1'b0;
        end else if (vid_gnt) begin
          n_vid++;
        end
      end
      checks++;
      if (n_vid != 4 || n_done != 1) begin
        errors++; $display("FAIL simultaneous_order got vid=%0d done=%0d want 4 1", n_vid, n_done);
      end
    end
    vid_req = 1'b0; cpu_req = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_contention;
    vid_addr = 13'h0300; vid_req = 1'b1;
    repeat (2) @(negedge clk);
    cpu_we = 1'b0; cpu_addr = 13'h0123; cpu_req = 1'b1;
    run_contention("contention", 8'hA5);
  endtask

  task automatic test_reset_abort;
    cpu_we = 1'b0; cpu_addr = 13'h0010; cpu_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_addr !== 13'h0010 || vid_gnt !== 1'b0) begin
      errors++; $display("FAIL abort_grant got addr=%h gnt=%b want 0010 0", mem_addr, vid_gnt);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if (cpu_done !== 1'b0 || mem_addr !== 13'h0 || cpu_rdata !== 8'h0 || cpu_wait !== 1'b1) begin
      errors++; $display("FAIL abort_reset got done=%b addr=%h rdata=%h wait=%b want 0 0000 00 1",
                         cpu_done, mem_addr, cpu_rdata, cpu_wait);
    end
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b0) begin
      errors++; $display("FAIL abort_no_done got %b want 0", cpu_done);
    end
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b0 || mem_addr !== 13'h0010) begin
      errors++; $display("FAIL abort_regrant got done=%b addr=%h want 0 0010", cpu_done, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b1 || cpu_rdata !== 8'h3C) begin
      errors++; $display("FAIL abort_complete got done=%b rdata=%h want 1 3c", cpu_done, cpu_rdata);
    end
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_cpu_read;
    test_cpu_write;
    test_video_stream;
    test_idle;
    test_simultaneous;
    test_contention;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
